usb_desc_sequencer: RTL and testbench
=====================================

USB_DESC_SEQUENCER -- requirements
Module: usb_desc_sequencer

Interface
REQ-001 SHALL have parameter DESC_BYTES, default 32, giving the descriptor length in bytes that the trace bit-mux holds (256 bits).
REQ-002 SHALL have parameter GET_DESC_REQ, default 8'h06, giving the bRequest code that is served.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port setup_valid, input, 1 bit: a one-cycle pulse meaning a decoded SETUP packet is present.
REQ-006 SHALL have port bRequest, input, 8 bits: the SETUP request code, sampled when setup_valid=1.
REQ-007 SHALL have port wLength, input, 16 bits: the host-requested byte count, sampled when setup_valid=1.
REQ-008 SHALL have port abort, input, 1 bit: the host cancels the transfer (new SETUP or bus reset).
REQ-009 SHALL have port select, output, 9 bits: the bit index driven to the trace bit-mux.
REQ-010 SHALL have port q, input, 1 bit: the selected descriptor bit, combinational from select in the same cycle.
REQ-011 SHALL have port tx_data, output, 8 bits: the assembled descriptor byte.
REQ-012 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-013 SHALL have port tx_ready, input, 1 bit: the downstream packet transmitter accepts the byte.
REQ-014 SHALL have ports busy, done and stall, outputs, 1 bit each: busy is the transfer status; done and stall are one-cycle completion pulses.

Function
REQ-015 SHALL implement the states IDLE, FETCH, SEND, DONE and STALL.
REQ-016 In IDLE with setup_valid=1 and bRequest==GET_DESC_REQ, SHALL latch len=min(wLength,DESC_BYTES) and clear byte_cnt and bit_cnt.
REQ-017 From that IDLE condition, SHALL go to DONE next cycle if len==0, else to FETCH.
REQ-018 In IDLE with setup_valid=1 and any other bRequest, SHALL go to STALL.
REQ-019 SHALL ignore setup_valid in every state other than IDLE.
REQ-020 In FETCH, SHALL drive select = 8*byte_cnt + bit_cnt (9-bit, no overflow since index ≤255).
REQ-021 In FETCH, SHALL sample q into byte bit position bit_cnt (LSB first) at the clock edge, then increment bit_cnt.
REQ-022 After bit_cnt==7 is sampled, SHALL load the completed byte into tx_data and enter SEND; a FETCH phase is exactly 8 cycles.
REQ-023 In SEND, tx_valid=1 and tx_data SHALL be held stable until tx_valid&&tx_ready.
REQ-024 On transfer in SEND, SHALL increment byte_cnt; if byte_cnt+1==len go to DONE, else go to FETCH with bit_cnt=0.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 STALL SHALL assert stall for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in FETCH and SEND, 0 otherwise.
REQ-028 select SHALL be 0 outside FETCH.
REQ-029 abort=1 in any state SHALL return to IDLE next cycle with tx_valid=0 and no done/stall pulse; abort has priority over setup_valid and tx_ready.
REQ-030 Latency: first tx_valid SHALL rise 9 cycles after the accepted setup_valid cycle; with tx_ready held 1, each subsequent byte SHALL take 9 cycles (8 FETCH + 1 SEND).

Reset
REQ-031 reset=1 SHALL force IDLE, byte_cnt=0, bit_cnt=0, len=0, select=0, tx_data=0, tx_valid=0, busy=0, done=0, stall=0 at the next edge.
REQ-032 reset SHALL have priority over abort and all other inputs; reset mid-transfer SHALL discard the partial byte.

Structure
REQ-033 A shared package SHALL hold the state enum, GET_DESC_REQ and the USB bRequest code constants.
REQ-034 The trace bit-mux SHALL remain a separate instance driven by select/q, external to this block.
REQ-035 No sub-module SHALL be required; byte assembly SHALL be an inline shift register.

Verification
REQ-036 d=256'h..0201_12 (byte0=8'h12, byte1=8'h01, byte2=8'h02), bRequest=06, wLength=3, tx_ready=1 -> bytes 12,01,02 at cycles 9,18,27; done pulse at cycle 28.
REQ-037 bRequest=06, wLength=64 -> exactly 32 bytes sent, then done; no select value above 255 is ever driven.
REQ-038 bRequest=06, wLength=0 -> done pulse with no tx_valid; bRequest=05 -> stall pulse, busy stays 0.
REQ-039 tx_ready held 0 for 5 cycles during byte1 -> tx_valid and tx_data stay constant, no FETCH advance; stream resumes correctly.
REQ-040 abort at cycle 12, and separately reset at cycle 12 -> IDLE next cycle, tx_valid=0, no done; a new request then completes normally.

Source files
------------

// File: rtl/usb_desc_sequencer_pkg.sv
// USB descriptor sequencer shared types.
// State encoding and standard bRequest codes.
package usb_desc_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    DONE  = 3'd3,
    STALL = 3'd4
  } state_t;

  localparam logic [7:0] REQ_GET_STATUS     = 8'h00;
  localparam logic [7:0] REQ_CLEAR_FEATURE  = 8'h01;
  localparam logic [7:0] REQ_SET_FEATURE    = 8'h03;
  localparam logic [7:0] REQ_SET_ADDRESS    = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;
  localparam logic [7:0] REQ_SET_DESCRIPTOR = 8'h07;
  localparam logic [7:0] REQ_GET_CONFIG     = 8'h08;
  localparam logic [7:0] REQ_SET_CONFIG     = 8'h09;

  localparam logic [7:0] GET_DESC_REQ = REQ_GET_DESCRIPTOR;

endpackage

// File: rtl/usb_desc_sequencer.sv
// Serves GET_DESCRIPTOR by walking an external bit-mux
// LSB first and streaming assembled bytes.
module usb_desc_sequencer
  import usb_desc_sequencer_pkg::*;
#(
  parameter int         DESC_BYTES   = 32,
  parameter logic [7:0] GET_DESC_REQ = usb_desc_sequencer_pkg::GET_DESC_REQ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        setup_valid,
  input  logic [7:0]  bRequest,
  input  logic [15:0] wLength,
  input  logic        abort,
  output logic [8:0]  select,
  input  logic        q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int LW = $clog2(DESC_BYTES + 1);

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] byte_cnt, byte_cnt_n;
  logic [LW-1:0] byte_inc;
  logic [LW-1:0] len_req;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    tx_data_n;

  assign byte_inc = byte_cnt + LW'(1);

  always_comb begin
    if (wLength > 16'(DESC_BYTES))
      len_req = LW'(DESC_BYTES);
    else
      len_req = LW'(wLength);
  end

  always_comb begin
    state_n    = state;
    len_n      = len;
    byte_cnt_n = byte_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_data_n  = tx_data;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (setup_valid) begin
            if (bRequest == GET_DESC_REQ) begin
              len_n      = len_req;
              byte_cnt_n = '0;
              bit_cnt_n  = '0;
              state_n    = (len_req == '0) ? DONE : FETCH;
            end else begin
              state_n = STALL;
            end
          end
        end
        FETCH: begin
          // shift right so the first sampled bit ends up at bit 0
          shreg_n   = {q, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tx_data_n = shreg_n;
            state_n   = SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            byte_cnt_n = byte_inc;
            bit_cnt_n  = '0;
            state_n    = (byte_inc == len) ? DONE : FETCH;
          end
        end
        DONE:    state_n = IDLE;
        STALL:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_data  <= '0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      byte_cnt <= byte_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx_data  <= tx_data_n;
    end
  end

  assign select   = (state == FETCH) ? 9'({byte_cnt, bit_cnt}) : '0;
  assign tx_valid = (state == SEND);
  assign busy     = (state == FETCH) || (state == SEND);
  assign done     = (state == DONE);
  assign stall    = (state == STALL);

endmodule

// File: tb/tb_usb_desc_sequencer.sv
// Scoreboard bench for usb_desc_sequencer with a
// behavioural 256-bit descriptor bit-mux.
module tb_usb_desc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        setup_valid = 1'b0;
  logic [7:0]  bRequest = 8'h00;
  logic [15:0] wLength = 16'h0000;
  logic        abort = 1'b0;
  logic [8:0]  select;
  logic        q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, done, stall;

  logic [255:0] desc;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  localparam int EV_BYTE  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_STALL = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t sbq[$];

  usb_desc_sequencer dut (
    .clk(clk), .reset(reset),
    .setup_valid(setup_valid), .bRequest(bRequest),
    .wLength(wLength), .abort(abort),
    .select(select), .q(q),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy),
    .done(done), .stall(stall)
  );

  assign q = desc[select[7:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] desc_byte(int i);
    if (i == 0) return 8'h12;
    if (i == 1) return 8'h01;
    if (i == 2) return 8'h02;
    return 8'(i * 37 + 5);
  endfunction

  task automatic check(string name, logic ok,
                       int act, int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h @cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic pop_ev(int kind, logic [7:0] data);
    ev_t e;
    if (sbq.size() == 0) begin
      check("unexpected_event", 1'b0, kind, -1);
    end else begin
      e = sbq.pop_front();
      check("event_kind", e.kind == kind, kind, e.kind);
      check("event_cycle", e.cyc == cyc, cyc, e.cyc);
      if (kind == EV_BYTE)
        check("tx_data", data == e.data, data, e.data);
    end
  endtask

  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) pop_ev(EV_BYTE, tx_data);
      if (done) pop_ev(EV_DONE, 8'h00);
      if (stall) begin
        pop_ev(EV_STALL, 8'h00);
        check("busy_in_stall", !busy, busy, 0);
      end
      if (busy && !tx_valid)
        check("select_range", select < 9'd256, select, 255);
      if (hold_v) begin
        check("hold_valid", tx_valid, tx_valid, 1);
        check("hold_data", tx_data == hold_d, tx_data, hold_d);
      end
      hold_v = tx_valid && !tx_ready && !abort;
      hold_d = tx_data;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [7:0] req, logic [15:0] wl);
    setup_valid = 1'b1;
    bRequest    = req;
    wLength     = wl;
    step();
    setup_valid = 1'b0;
    bRequest    = 8'h00;
    wLength     = 16'h0000;
  endtask

  task automatic push_desc(int t0, int n);
    ev_t e;
    for (int k = 0; k < n; k++) begin
      e.kind = EV_BYTE;
      e.data = desc_byte(k);
      e.cyc  = t0 + 9 * (k + 1);
      sbq.push_back(e);
    end
    e.kind = EV_DONE;
    e.data = 8'h00;
    e.cyc  = t0 + 9 * n + 1;
    sbq.push_back(e);
  endtask

  task automatic push_one(int kind, logic [7:0] d, int c);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < lim) begin
      step();
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 1'b0, sbq.size(), 0);
      sbq.delete();
    end
    repeat (4) step();
  endtask

  task automatic check_idle(string name);
    check({name, "_tx_valid"}, !tx_valid, tx_valid, 0);
    check({name, "_busy"}, !busy, busy, 0);
    check({name, "_done"}, !done, done, 0);
    check({name, "_select"}, select == 9'd0, select, 0);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 32; i++)
      desc[i*8 +: 8] = desc_byte(i);

    repeat (3) step();
    check_idle("reset");
    check("reset_tx_data", tx_data == 8'h00, tx_data, 0);
    check("reset_stall", !stall, stall, 0);
    reset = 1'b0;
    step();

    // three-byte descriptor, tx_ready held high
    t0 = cyc;
    push_desc(t0, 3);
    issue(8'h06, 16'd3);
    drain(100);

    // oversize request clamps to 32 bytes; late SETUP ignored
    t0 = cyc;
    push_desc(t0, 32);
    issue(8'h06, 16'd64);
    goto(t0 + 20);
    issue(8'h05, 16'd1);
    drain(400);

    // zero length completes immediately
    t0 = cyc;
    push_one(EV_DONE, 8'h00, t0 + 1);
    issue(8'h06, 16'd0);
    drain(20);

    // unsupported request stalls
    t0 = cyc;
    push_one(EV_STALL, 8'h00, t0 + 1);
    issue(8'h05, 16'd8);
    drain(20);

    // back-pressure during byte 1
    t0 = cyc;
    push_one(EV_BYTE, desc_byte(0), t0 + 9);
    push_one(EV_BYTE, desc_byte(1), t0 + 23);
    push_one(EV_BYTE, desc_byte(2), t0 + 32);
    push_one(EV_DONE, 8'h00, t0 + 33);
    issue(8'h06, 16'd3);
    goto(t0 + 18);
    tx_ready = 1'b0;
    goto(t0 + 23);
    tx_ready = 1'b1;
    drain(100);

    // abort mid-transfer
    t0 = cyc;
    push_one(EV_BYTE, desc_byte(0), t0 + 9);
    issue(8'h06, 16'd3);
    goto(t0 + 12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort");
    drain(20);
    repeat (30) step();

    t0 = cyc;
    push_desc(t0, 2);
    issue(8'h06, 16'd2);
    drain(100);

    // reset mid-transfer
    t0 = cyc;
    push_one(EV_BYTE, desc_byte(0), t0 + 9);
    issue(8'h06, 16'd3);
    goto(t0 + 12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("midreset");
    check("midreset_tx_data", tx_data == 8'h00, tx_data, 0);
    drain(20);
    repeat (30) step();

    t0 = cyc;
    push_desc(t0, 3);
    issue(8'h06, 16'd3);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
